// File: rtl/rstx01a.sv
// Byte-wide UART transmitter fed by a one-cycle BitTick enable, with a small FIFO.
// Optional even-parity bit compiled in when RSTX01A_PARITY_EN is defined.
module rstx01a #(
    parameter int FIFO_AW   = 2,
    parameter int STOP_BITS = 1
) (
    input  logic               F50Clk,
    input  logic               reset,
    input  logic               BitTick,
    input  logic [7:0]         TxData,
    input  logic               TxValid,
    output logic               TxReady,
    output logic               TxD,
    output logic               Busy,
    output logic [FIFO_AW:0]   FifoLevel
);

    localparam int              DEPTH     = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_LVL = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef RSTX01A_PARITY_EN
        PARITY,
`endif
        STOP
    } txState_t;

    logic [7:0]         fifoMem [DEPTH];
    logic [FIFO_AW-1:0] wrPtr;
    logic [FIFO_AW-1:0] rdPtr;
    logic [FIFO_AW:0]   level;
    logic               push;
    logic               pop;
    logic               lastStop;

    txState_t           state;
    logic [7:0]         shiftReg;
    logic [2:0]         bitCnt;
    logic               stopCnt;
`ifdef RSTX01A_PARITY_EN
    logic               parityBit;
`endif

    assign TxReady   = (level != FULL_LVL);
    assign push      = TxValid & TxReady;
    assign lastStop  = (stopCnt == 1'(STOP_BITS - 1));
    // Pop eligibility looks only at the registered level, so a same-cycle push waits a cycle.
    assign pop       = BitTick & (level != '0) &
                       ((state == IDLE) | ((state == STOP) & lastStop));
    assign FifoLevel = level;
    assign Busy      = (state != IDLE) | (level != '0);

    // NOTE: storage has no reset; stale bytes are unreachable once the pointers are cleared.
    always_ff @(posedge F50Clk) begin
        if (push)
            fifoMem[wrPtr] <= TxData;
    end

    // NOTE: every register is updated with <= so all blocks see the pre-edge values.
    always_ff @(posedge F50Clk or posedge reset) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            level <= '0;
        end else begin
            if (push)
                wrPtr <= wrPtr + 1'b1;
            if (pop)
                rdPtr <= rdPtr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge F50Clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            TxD       <= 1'b1;
            shiftReg  <= '0;
            bitCnt    <= '0;
            stopCnt   <= 1'b0;
`ifdef RSTX01A_PARITY_EN
            parityBit <= 1'b0;
`endif
        end else if (BitTick) begin
            case (state)
                IDLE: begin
                    TxD <= 1'b1;
                    if (pop) begin
                        shiftReg  <= fifoMem[rdPtr];
`ifdef RSTX01A_PARITY_EN
                        parityBit <= ^fifoMem[rdPtr];
`endif
                        TxD       <= 1'b0;
                        state     <= START;
                    end
                end
                START: begin
                    TxD      <= shiftReg[0];
                    shiftReg <= shiftReg >> 1;
                    bitCnt   <= '0;
                    state    <= DATA;
                end
                DATA: begin
                    if (bitCnt == 3'd7) begin
`ifdef RSTX01A_PARITY_EN
                        TxD     <= parityBit;
                        state   <= PARITY;
`else
                        TxD     <= 1'b1;
                        stopCnt <= 1'b0;
                        state   <= STOP;
`endif
                    end else begin
                        TxD      <= shiftReg[0];
                        shiftReg <= shiftReg >> 1;
                        bitCnt   <= bitCnt + 3'd1;
                    end
                end
`ifdef RSTX01A_PARITY_EN
                PARITY: begin
                    TxD     <= 1'b1;
                    stopCnt <= 1'b0;
                    state   <= STOP;
                end
`endif
                STOP: begin
                    if (!lastStop) begin
                        stopCnt <= stopCnt + 1'b1;
                    end else if (pop) begin
                        // Back-to-back frame: the next start bit replaces the idle period.
                        shiftReg  <= fifoMem[rdPtr];
`ifdef RSTX01A_PARITY_EN
                        parityBit <= ^fifoMem[rdPtr];
`endif
                        TxD       <= 1'b0;
                        state     <= START;
                    end else begin
                        TxD   <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: begin
                    TxD   <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rstx01a.sv
// Self-checking bench for rstx01a: one instance with 1 stop bit, one with 2 stop bits,
// each compared every cycle against a bit-queue model of the serial line.
module tb_rstx01a;

`ifdef RSTX01A_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int DEPTH = 4;

    logic       F50Clk = 1'b0;
    logic       reset  = 1'b1;
    logic       BitTick = 1'b0;
    logic [7:0] TxData  = '0;
    logic       TxValid = 1'b0;

    logic [1:0] TxDW;
    logic [1:0] TxReadyW;
    logic [1:0] BusyW;
    logic [2:0] LevelW [2];

    int checkCount = 0;
    int failCount  = 0;

    always #10 F50Clk = ~F50Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            failCount++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : lane
        rstx01a #(.FIFO_AW(2), .STOP_BITS(g + 1)) dut (
            .F50Clk    (F50Clk),
            .reset     (reset),
            .BitTick   (BitTick),
            .TxData    (TxData),
            .TxValid   (TxValid),
            .TxReady   (TxReadyW[g]),
            .TxD       (TxDW[g]),
            .Busy      (BusyW[g]),
            .FifoLevel (LevelW[g])
        );

        // Model: queued bytes, plus the bits of the frame still to be shifted out.
        logic [7:0] fq[$];
        bit         pb[$];
        bit         inFrame = 1'b0;
        bit         expTxD  = 1'b1;
        logic [7:0] d;
        int         lvl;

        always @(negedge F50Clk) begin
            if (reset) begin
                fq.delete();
                pb.delete();
                inFrame = 1'b0;
                expTxD  = 1'b1;
            end
            check($sformatf("txd_s%0d", g + 1), TxDW[g], expTxD);
            check($sformatf("level_s%0d", g + 1), LevelW[g], fq.size());
            check($sformatf("ready_s%0d", g + 1), TxReadyW[g], fq.size() < DEPTH);
            check($sformatf("busy_s%0d", g + 1), BusyW[g], inFrame || fq.size() != 0);
            if (!reset) begin
                lvl = fq.size();
                if (BitTick) begin
                    if (pb.size() == 0) begin
                        if (lvl != 0) begin
                            d = fq.pop_front();
                            pb.push_back(1'b0);
                            for (int i = 0; i < 8; i++) pb.push_back(d[i]);
                            if (P == 1) pb.push_back(^d);
                            for (int s = 0; s < g + 1; s++) pb.push_back(1'b1);
                            inFrame = 1'b1;
                        end else begin
                            inFrame = 1'b0;
                        end
                    end
                    expTxD = (pb.size() != 0) ? pb.pop_front() : 1'b1;
                end
                if (TxValid && lvl < DEPTH) fq.push_back(TxData);
            end
        end
    end

    task automatic step(input bit tick, input bit valid, input logic [7:0] data);
        BitTick = tick;
        TxValid = valid;
        TxData  = data;
        @(posedge F50Clk);
        #2;
    endtask

    // One bit period: `gap` quiet cycles followed by the tick cycle.
    task automatic bitPeriod(input int gap);
        for (int i = 0; i < gap; i++) step(1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && BusyW != 2'b00; i++) bitPeriod(2);
        check("drain_busy", BusyW, 2'b00);
    endtask

    // Single frame on the 1-stop lane: 13 ticks compared against a literal bit pattern.
    task automatic runFrame(input string tag, input logic [7:0] data, input logic [12:0] expBits);
        step(1'b0, 1'b1, data);
        for (int k = 0; k < 13; k++) begin
            bitPeriod(7);
            check($sformatf("%s_bit%0d", tag, k), TxDW[0], expBits[k]);
            if (k == 9 + P) check($sformatf("%s_busy_in_stop", tag), BusyW[0], 1'b1);
        end
        check($sformatf("%s_busy_done", tag), BusyW, 2'b00);
    endtask

    initial begin
        logic [12:0] expA5;
        logic [12:0] exp07;
        logic [7:0]  rx;
        int          tickCnt;
        bit          tick;

        repeat (2) @(posedge F50Clk);
        check("rst_txd", TxDW, 2'b11);
        #2 reset = 1'b0;
        check("rst_ready", TxReadyW, 2'b11);
        check("rst_busy", BusyW, 2'b00);
        check("rst_level", LevelW[0], 0);

        expA5 = (P == 1) ? 13'b1_1101_0100_1010 : 13'b1_1111_0100_1010;
        exp07 = 13'b1_1110_0000_1110;
        runFrame("a5", 8'hA5, expA5);
        runFrame("x07", 8'h07, exp07);

        // Back-to-back frames on the 2-stop lane.
        step(1'b0, 1'b1, 8'h55);
        step(1'b0, 1'b1, 8'hAA);
        for (int k = 0; k < 2 * (11 + P) + 2; k++) begin
            bitPeriod(3);
            if (k == 9 + P || k == 10 + P) check("b2b_stop", TxDW[1], 1'b1);
            if (k == 11 + P) begin
                check("b2b_start2", TxDW[1], 1'b0);
                check("b2b_busy", BusyW[1], 1'b1);
            end
        end
        drain();

        // Fill with the tick held low; the fifth write must be dropped.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'h10 + 8'(i));
        step(1'b0, 1'b0, 8'h00);
        check("full_level", LevelW[0], 4);
        check("full_ready", TxReadyW, 2'b00);
        step(1'b0, 1'b1, 8'hEE);
        step(1'b0, 1'b0, 8'h00);
        check("full_drop", LevelW[1], 4);
        drain();

        // Push in the same cycle as a pop with one byte queued.
        step(1'b0, 1'b1, 8'h3C);
        step(1'b1, 1'b1, 8'hC3);
        check("pushpop_level", LevelW[0], 1);
        rx = '0;
        for (int k = 1; k <= 10 + P + 9; k++) begin
            bitPeriod(2);
            if (k > 10 + P && k <= 10 + P + 8) rx[k - 11 - P] = TxDW[0];
        end
        check("pushpop_next", rx, 8'hC3);
        drain();

        // Reset while data bit 3 is on the line.
        step(1'b0, 1'b1, 8'hF0);
        step(1'b0, 1'b1, 8'h11);
        step(1'b0, 1'b1, 8'h22);
        for (int k = 0; k < 5; k++) bitPeriod(2);
        check("pre_rst_bit3", TxDW, 2'b00);
        #3 reset = 1'b1;
        #1;
        check("midrst_txd", TxDW, 2'b11);
        check("midrst_level", LevelW[0], 0);
        check("midrst_busy", BusyW, 2'b00);
        check("midrst_ready", TxReadyW, 2'b11);
        @(posedge F50Clk);
        #2 reset = 1'b0;

        // Randomised traffic with irregular tick spacing (never two adjacent ticks).
        tickCnt = 3;
        for (int i = 0; i < 4000; i++) begin
            tick = (tickCnt == 0);
            tickCnt = tick ? int'($urandom_range(1, 9)) : tickCnt - 1;
            step(tick, ($urandom_range(0, 9) < 4), 8'($urandom));
        end
        step(1'b0, 1'b0, 8'h00);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
